complex_conj_mulp_seq: RTL and testbench

- Inverse-QFT phase rotator: multiplies a complex amplitude by the conjugate twiddle (cos − j·sin), undoing the forward rotation.
- A single shared 8x12 signed multiplier is time-multiplexed over 4 cycles, sequenced by an FSM.
- Sits on the inverse-QFT datapath, downstream of the twiddle source, with valid/ready streaming on both sides.

---
 rtl/qft_pkg.sv | 35 +++
 rtl/qft_mul8x12.sv | 14 +
 rtl/complex_conj_mulp_seq.sv | 155 +++++++++++++++
 tb/tb_complex_conj_mulp_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/qft_pkg.sv
// Shared widths, FSM state type and output scaling for the inverse-QFT conjugate rotator.
// Rounding mode of scale_out is selected by COMPLEX_CONJ_ROUND_EN (undefined: floor).
package qft_pkg;

  localparam int unsigned IN_W   = 8;
  localparam int unsigned TW_W   = 12;
  localparam int unsigned FRAC   = 10;
  localparam int unsigned OUT_W  = 13;
  localparam int unsigned ACC_W  = 22;
  localparam int unsigned PROD_W = IN_W + TW_W;

  // Q1.10 reference twiddle values
  localparam logic [TW_W-1:0] ONE     = 12'h400;
  localparam logic [TW_W-1:0] NEG_TWO = 12'h800;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4,
    HOLD = 3'd5
  } state_e;

  // Drop the Q1.10 fraction; |result| <= 512 so the narrowing never clips.
  function automatic logic signed [OUT_W-1:0] scale_out(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] t;
    t = acc;
`ifdef COMPLEX_CONJ_ROUND_EN
    t = t + ACC_W'(2 ** (FRAC - 1));
`endif
    return OUT_W'(t >>> FRAC);
  endfunction

endpackage

// File: rtl/qft_mul8x12.sv
// Combinational signed 8x12 -> 20 multiplier, shared across the rotator's four product phases.
module qft_mul8x12
  import qft_pkg::*;
(
  input  logic signed [IN_W-1:0]   a_i,
  input  logic signed [TW_W-1:0]   b_i,
  output logic signed [PROD_W-1:0] p_o
);

  always_comb begin
    p_o = PROD_W'(a_i) * PROD_W'(b_i);
  end

endmodule

// File: rtl/complex_conj_mulp_seq.sv
// Inverse-QFT phase rotator: (in_r + j*in_i) * (cos - j*sin), one shared multiplier over 4 cycles.
// Build option: COMPLEX_CONJ_ROUND_EN selects round-half-up instead of floor on the outputs.
module complex_conj_mulp_seq
  import qft_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_r,
  input  logic [IN_W-1:0]        in_i,
  input  logic [TW_W-1:0]        cos_2p_by,
  input  logic [TW_W-1:0]        sin_2p_by,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_r,
  output logic [OUT_W-1:0]       out_i
);

  state_e                   state_q, state_d;
  logic signed [IN_W-1:0]   in_r_q, in_r_d;
  logic signed [IN_W-1:0]   in_i_q, in_i_d;
  logic signed [TW_W-1:0]   cos_q, cos_d;
  logic signed [TW_W-1:0]   sin_q, sin_d;
  logic signed [ACC_W-1:0]  acc_r_q, acc_r_d;
  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d;
  logic signed [OUT_W-1:0]  out_r_q, out_r_d;
  logic signed [OUT_W-1:0]  out_i_q, out_i_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [IN_W-1:0]   mul_a;
  logic signed [TW_W-1:0]   mul_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  // Operand schedule: P0 cos*r, P1 sin*i, P2 cos*i, P3 sin*r
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      P0: begin mul_a = in_r_q; mul_b = cos_q; end
      P1: begin mul_a = in_i_q; mul_b = sin_q; end
      P2: begin mul_a = in_i_q; mul_b = cos_q; end
      P3: begin mul_a = in_r_q; mul_b = sin_q; end
      default: begin mul_a = '0; mul_b = '0; end
    endcase
  end

  qft_mul8x12 u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (prod)
  );

  assign prod_ext = ACC_W'(prod);

  always_comb begin
    state_d     = state_q;
    in_r_d      = in_r_q;
    in_i_d      = in_i_q;
    cos_d       = cos_q;
    sin_d       = sin_q;
    acc_r_d     = acc_r_q;
    acc_i_d     = acc_i_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_r_d  = in_r;
          in_i_d  = in_i;
          cos_d   = cos_2p_by;
          sin_d   = sin_2p_by;
          acc_r_d = '0;
          acc_i_d = '0;
          state_d = P0;
        end
      end
      P0: begin
        acc_r_d = prod_ext;
        state_d = P1;
      end
      P1: begin
        acc_r_d = acc_r_q + prod_ext;
        state_d = P2;
      end
      P2: begin
        acc_i_d = prod_ext;
        state_d = P3;
      end
      P3: begin
        acc_i_d     = acc_i_q - prod_ext;
        out_r_d     = scale_out(acc_r_q);
        out_i_d     = scale_out(acc_i_q - prod_ext);
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          // Retire and accept on the same edge so a busy stream loses no cycle.
          if (in_valid) begin
            in_r_d  = in_r;
            in_i_d  = in_i;
            cos_d   = cos_2p_by;
            sin_d   = sin_2p_by;
            acc_r_d = '0;
            acc_i_d = '0;
            state_d = P0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_r_q      <= '0;
      in_i_q      <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      acc_r_q     <= '0;
      acc_i_q     <= '0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_r_q      <= in_r_d;
      in_i_q      <= in_i_d;
      cos_q       <= cos_d;
      sin_q       <= sin_d;
      acc_r_q     <= acc_r_d;
      acc_i_q     <= acc_i_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;

endmodule

// File: tb/tb_complex_conj_mulp_seq.sv
// Scoreboard bench for complex_conj_mulp_seq; expectations come from an integer floor-division model.
module tb_complex_conj_mulp_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_r, in_i;
  logic [11:0] cos_2p_by, sin_2p_by;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_r, out_i;

  typedef struct {
    int r;
    int i;
  } res_t;

  res_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int unsigned rise_cyc = 0;
  logic        ov_prev = 1'b0;

  complex_conj_mulp_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_i      (in_i),
    .cos_2p_by (cos_2p_by),
    .sin_2p_by (sin_2p_by),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int floor_div1024(input int p);
    int q;
    q = p / 1024;
    if ((p < 0) && ((p % 1024) != 0)) q = q - 1;
    return q;
  endfunction

  function automatic res_t model(input int r, input int i, input int c, input int s);
    res_t x;
    int   pr, pi;
    pr = c * r + s * i;
    pi = c * i - s * r;
`ifdef COMPLEX_CONJ_ROUND_EN
    pr = pr + 512;
    pi = pi + 512;
`endif
    x.r = floor_div1024(pr);
    x.i = floor_div1024(pi);
    return x;
  endfunction

  // Results are checked on the negedge before the retiring edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !ov_prev) rise_cyc = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          res_t e;
          e = sb.pop_front();
          check("out_r", int'($signed(out_r)), e.r);
          check("out_i", int'($signed(out_i)), e.i);
        end
      end
    end
    ov_prev = out_valid;
  end

  task automatic send(input int r, input int i, input int c, input int s);
    bit ok;
    ok        = 1'b0;
    in_r      = 8'(r);
    in_i      = 8'(i);
    cos_2p_by = 12'(c);
    sin_2p_by = 12'(s);
    in_valid  = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(r, i, c, s));
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        ok      = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("wait_out", int'(seen), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_r      = '0;
    in_i      = '0;
    cos_2p_by = '0;
    sin_2p_by = '0;
    #12;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_r", int'($signed(out_r)), 0);
    check("rst_out_i", int'($signed(out_i)), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", int'(in_ready), 1);

    // Identity twiddle plus latency: accept edge, then P0..P3 edges raise out_valid.
    send(5, -3, 1024, 0);
    drain();
    check("latency", int'(rise_cyc - acc_cyc), 4);

    send(10, 20, 0, 1024);
    drain();
    send(100, 0, 724, 724);
    drain();
    send(-128, -128, -2048, -2048);
    drain();

    // Backpressure: result must sit still in HOLD with in_ready low.
    out_ready = 1'b0;
    send(37, -90, -300, 900);
    wait_out();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_r", int'($signed(out_r)), sb[0].r);
      check("bp_out_i", int'($signed(out_i)), sb[0].i);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(-50, 60, 1000, -700);
    check("b2b_valid_drop", int'(out_valid), 0);
    drain();
    check("b2b_latency", int'(rise_cyc - acc_cyc), 4);

    // Continuous stream of random samples.
    for (int n = 0; n < 8; n++) begin
      send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
    end
    drain();

    // Non-trivial last result so the reset clearing below is observable.
    send(-100, 90, 1000, -1000);
    drain();

    // Reset during P2: in-flight sample is dropped, outputs clear immediately.
    send(77, -33, 500, 500);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mr_out_valid", int'(out_valid), 0);
    check("mr_out_r", int'($signed(out_r)), 0);
    check("mr_out_i", int'($signed(out_i)), 0);
    check("mr_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mr_idle_ready", int'(in_ready), 1);
    send(1, 1, 1024, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
